// File: rtl/mux_pkg.sv
// Shared constants for the multiplexer scanner: default geometry and FSM encoding.
package mux_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NCH   = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/muxn.sv
// Combinational N:1 selector over a flat bus of NCH channels, WIDTH bits each.
module muxn
  import mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH,
  localparam int SELW = $clog2(NCH)
) (
  output logic [WIDTH-1:0]     q,
  input  logic [NCH*WIDTH-1:0] d,
  input  logic [SELW-1:0]      a
);

  assign q = d[a*WIDTH +: WIDTH];

endmodule

// File: rtl/mux_scan.sv
// Channel multiplexer with direct-select and auto-scan modes behind a one-beat
// valid/ready output register.
module mux_scan
  import mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] d,
  input  logic [SELW-1:0]      a,
  input  logic                 mode,
  input  logic                 start,
  input  logic                 q_ready,
  output logic [WIDTH-1:0]     q,
  output logic [SELW-1:0]      q_ch,
  output logic                 q_valid,
  output logic                 busy,
  output logic                 done
);

  localparam logic [SELW-1:0] LAST_IDX = SELW'(NCH - 1);

  logic [1:0]       state_r;
  logic [SELW-1:0]  idx_r;
  logic [WIDTH-1:0] q_r;
  logic [SELW-1:0]  q_ch_r;
  logic             q_valid_r;
  logic             busy_r;
  logic             done_r;
  logic             slot_free_s;
  logic [SELW-1:0]  sel_s;
  logic [WIDTH-1:0] mux_q_s;

  assign slot_free_s = !q_valid_r || q_ready;
  assign sel_s       = busy_r ? idx_r : a;

  muxn #(
    .WIDTH (WIDTH),
    .NCH   (NCH)
  ) u_muxn (
    .q (mux_q_s),
    .d (d),
    .a (sel_s)
  );

  // Scan FSM and output register; busy mirrors state != IDLE as a register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      idx_r     <= '0;
      q_r       <= '0;
      q_ch_r    <= '0;
      q_valid_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!mode) begin
            if (slot_free_s) begin
              q_r       <= mux_q_s;
              q_ch_r    <= a;
              q_valid_r <= 1'b1;
            end
          end else begin
            if (slot_free_s) begin
              q_valid_r <= 1'b0;
            end
            if (start) begin
              state_r <= ST_SCAN;
              busy_r  <= 1'b1;
              idx_r   <= '0;
            end
          end
        end
        ST_SCAN: begin
          // Back-pressure simply stalls here: idx and the held beat stay put.
          if (slot_free_s) begin
            q_r       <= mux_q_s;
            q_ch_r    <= idx_r;
            q_valid_r <= 1'b1;
            if (idx_r == LAST_IDX) begin
              state_r <= ST_DRAIN;
              idx_r   <= '0;
            end else begin
              idx_r <= idx_r + SELW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (q_ready) begin
            q_valid_r <= 1'b0;
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          idx_r     <= '0;
          q_valid_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign q       = q_r;
  assign q_ch    = q_ch_r;
  assign q_valid = q_valid_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_mux_scan.sv
// Self-checking bench for mux_scan: behavioural beat model plus directed scans.
module tb_mux_scan;

  localparam int WIDTH = 8;
  localparam int NCH   = 16;
  localparam int SELW  = 4;

  logic                 clk;
  logic                 rst_n;
  logic [NCH*WIDTH-1:0] d;
  logic [SELW-1:0]      a;
  logic                 mode;
  logic                 start;
  logic                 q_ready;
  logic [WIDTH-1:0]     q;
  logic [SELW-1:0]      q_ch;
  logic                 q_valid;
  logic                 busy;
  logic                 done;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  mux_scan #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .d       (d),
    .a       (a),
    .mode    (mode),
    .start   (start),
    .q_ready (q_ready),
    .q       (q),
    .q_ch    (q_ch),
    .q_valid (q_valid),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Model: a scan is "beats still to load" plus an active flag; the slot holds one beat.
  int               m_left;
  logic             m_busy, m_valid, m_done, m_free;
  logic [WIDTH-1:0] m_q;
  logic [SELW-1:0]  m_ch;

  always @(posedge clk) begin
    m_free = !m_valid || q_ready;
    if (!rst_n) begin
      m_left = 0; m_busy = 0; m_valid = 0; m_done = 0; m_q = '0; m_ch = '0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        if (m_left > 0) begin
          if (m_free) begin
            m_ch = SELW'(NCH - m_left);
            m_q = d[m_ch*WIDTH +: WIDTH];
            m_valid = 1;
            m_left--;
          end
        end else if (q_ready) begin
          m_valid = 0; m_busy = 0; m_done = 1;
        end
      end else if (!mode) begin
        if (m_free) begin
          m_q = d[a*WIDTH +: WIDTH]; m_ch = a; m_valid = 1;
        end
      end else begin
        if (m_free) m_valid = 0;
        if (start) begin m_busy = 1; m_left = NCH; end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_q", q, m_q);
      chk("m_q_ch", q_ch, m_ch);
      chk("m_q_valid", q_valid, m_valid);
      chk("m_busy", busy, m_busy);
      chk("m_done", done, m_done);
    end
  end

  task automatic set_pattern();
    for (int i = 0; i < NCH; i++) d[i*WIDTH +: WIDTH] = 8'h10 + 8'(i);
  endtask

  // One scan from IDLE; bp = stall percentage, noise toggles ignored inputs, pin4 stalls at channel 4.
  task automatic scan_run(input int bp, input bit noise, input bit pin4);
    int beats = 0;
    int cyc = 0;
    int busy_cyc = 0;
    int stall4 = 0;
    bit got_done = 0;
    logic [NCH-1:0] seen = '0;
    mode = 1'b1; start = 1'b1; q_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("scan_busy_start", busy, 1);
    while (!got_done && cyc < 400) begin
      if (busy) busy_cyc++;
      if (done) begin
        got_done = 1;
        chk("done_busy_low", busy, 0);
        if (bp == 0 && !pin4) chk("done_cycle", cyc, NCH + 1);
      end else begin
        if (pin4 && q_valid && q_ch == 4'd4 && stall4 < 3) begin
          if (stall4 > 0) begin
            chk("bp_hold_q", q, 8'h14);
            chk("bp_hold_v", q_valid, 1);
          end
          q_ready = 1'b0;
          stall4++;
        end else begin
          q_ready = (bp == 0) ? 1'b1 : ($urandom_range(99) >= bp);
        end
        if (noise) begin
          start = 1'($urandom); mode = 1'($urandom); a = SELW'($urandom);
        end
        if (q_valid && q_ready) begin
          chk("beat_ch", q_ch, beats);
          chk("beat_q", q, 8'h10 + beats);
          if (bp == 0 && !pin4) chk("beat_cycle", cyc, beats + 1);
          seen[q_ch] = 1'b1;
          beats++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0; mode = 1'b1;
    chk("scan_done_seen", got_done, 1);
    chk("scan_beats", beats, NCH);
    chk("scan_all_seen", seen, {NCH{1'b1}});
    if (bp == 0 && !pin4) chk("busy_cycles", busy_cyc, NCH + 1);
    if (pin4) chk("bp_stalls", stall4, 3);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; mode = 1'b0; start = 1'b0; a = '0; q_ready = 1'b1;
    d = '0;
    set_pattern();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_q", q, 0);
    chk("rst_q_ch", q_ch, 0);
    chk("rst_q_valid", q_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk_en = 1'b1;

    rst_n = 1'b1; mode = 1'b0; a = 4'd5;
    @(negedge clk);
    chk("direct5_q", q, 8'h15);
    chk("direct5_ch", q_ch, 5);
    chk("direct5_v", q_valid, 1);
    a = 4'd9;
    @(negedge clk);
    chk("direct9_q", q, 8'h19);
    chk("direct9_ch", q_ch, 9);

    scan_run(0, 0, 0);
    scan_run(0, 0, 0);
    scan_run(0, 0, 1);
    scan_run(0, 1, 0);
    scan_run(40, 1, 0);

    mode = 1'b1; start = 1'b1; q_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(q_valid && q_ch == 4'd7) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reach", q_ch, 7);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_q", q, 0);
    chk("rst_mid_ch", q_ch, 0);
    chk("rst_mid_v", q_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_nodone", done, 0);
    scan_run(0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      d = {$urandom, $urandom, $urandom, $urandom};
      mode = ($urandom_range(3) != 0);
      start = ($urandom_range(3) == 0);
      a = SELW'($urandom);
      q_ready = ($urandom_range(3) != 0);
      rst_n = ($urandom_range(299) != 0);
    end
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
